// File: rtl/branch_resolve_unit_pkg.sv
// ----------------------------------------------------------------------------
// gpu_branch_pkg
//   Shared types and helpers for the branch resolve unit.
//   - RISC-V branch funct3 encodings
//   - FSM state and chunk-compare result enums
//   - small decode helpers used by the top-level FSM
// ----------------------------------------------------------------------------
package gpu_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} br_state_t;

  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_res_t;

  // 010 and 011 are the only unassigned branch encodings.
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Signed compares are done by flipping both sign bits and comparing unsigned.
  function automatic logic is_signed_cmp(input logic [2:0] f3);
    return (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input cmp_res_t r);
    logic tk;
    tk = 1'b0;
    case (f3)
      F3_BEQ:           tk = (r == CMP_EQ);
      F3_BNE:           tk = (r != CMP_EQ);
      F3_BLT, F3_BLTU:  tk = (r == CMP_LT);
      F3_BGE, F3_BGEU:  tk = (r != CMP_LT);
      default:          tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_if
//   Request/response bundle of the branch resolve unit.
//   Request side : in_valid, in_ready, rs1, rs2, funct3, pc, imm
//   Response side: out_valid, out_ready, taken, target, illegal
//   master = producer of requests / consumer of results (core side)
//   slave  = the branch resolve unit
// ----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    rs1;
  logic [WIDTH-1:0]    rs2;
  logic [2:0]          funct3;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] imm;
  logic                out_valid;
  logic                out_ready;
  logic                taken;
  logic [PC_WIDTH-1:0] target;
  logic                illegal;

  modport master (
    output in_valid, rs1, rs2, funct3, pc, imm, out_ready,
    input  in_ready, out_valid, taken, target, illegal
  );

  modport slave (
    input  in_valid, rs1, rs2, funct3, pc, imm, out_ready,
    output in_ready, out_valid, taken, target, illegal
  );
endinterface

// File: rtl/branch_resolve_unit_chunk_cmp.sv
// ----------------------------------------------------------------------------
// chunk_cmp
//   Combinational unsigned magnitude compare of one CHUNK-bit slice.
//   a_i, b_i : operand chunks
//   res_o    : CMP_EQ / CMP_LT / CMP_GT of a_i relative to b_i
// ----------------------------------------------------------------------------
module chunk_cmp
  import gpu_branch_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output cmp_res_t         res_o
);

  always_comb begin
    res_o = CMP_EQ;
    if (a_i > b_i)      res_o = CMP_GT;
    else if (a_i < b_i) res_o = CMP_LT;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves a RISC-V conditional branch: taken/not-taken plus target = pc+imm.
//   Operands are compared CHUNK bits per cycle, MSB chunk first, stopping at
//   the first chunk that differs. One operation in flight at a time.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort, returns to IDLE and clears the result
//   bus   : slave side of branch_resolve_unit_if (request + result handshakes)
// ----------------------------------------------------------------------------
module branch_resolve_unit
  import gpu_branch_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHUNK    = 8,
  parameter int PC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  branch_resolve_unit_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  br_state_t           state_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIDTH-1:0]    a_d, b_d;
  logic [2:0]          f3_q;
  logic [IDX_W-1:0]    idx_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                taken_q;
  logic                illegal_q;
  logic [PC_WIDTH-1:0] target_q;
  logic [PC_WIDTH-1:0] target_d;
  logic [CHUNK-1:0]    a_chunk, b_chunk;
  cmp_res_t            cmp_res;
  logic                scan_last;

  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so a single unsigned chunk comparator serves every branch type.
  always_comb begin
    a_d = bus.rs1;
    b_d = bus.rs2;
    a_d[WIDTH-1] = bus.rs1[WIDTH-1] ^ is_signed_cmp(bus.funct3);
    b_d[WIDTH-1] = bus.rs2[WIDTH-1] ^ is_signed_cmp(bus.funct3);
  end

  assign target_d = bus.pc + bus.imm;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_i   (a_chunk),
    .b_i   (b_chunk),
    .res_o (cmp_res)
  );

  // A differing chunk decides the order; equal chunks decide only at index 0.
  assign scan_last = (cmp_res != CMP_EQ) || (idx_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f3_q        <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      target_q    <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      target_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= a_d;
            b_q        <= b_d;
            f3_q       <= bus.funct3;
            idx_q      <= IDX_TOP;
            target_q   <= target_d;
            in_ready_q <= 1'b0;
            if (is_illegal_f3(bus.funct3)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              taken_q     <= 1'b0;
              illegal_q   <= 1'b1;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          if (scan_last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            taken_q     <= branch_taken(f3_q, cmp_res);
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The target register is loaded on accept; gating it keeps the result bus
  // at zero whenever no result is being offered.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.taken     = taken_q;
  assign bus.illegal   = illegal_q;
  assign bus.target    = out_valid_q ? target_q : '0;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed and randomized bench for branch_resolve_unit (WIDTH=32, CHUNK=8).
//   A behavioural model tracks the one in-flight operation and its expected
//   result; a negedge monitor compares every output on every cycle.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic clk;
  logic rst_n;
  logic flush;

  int n_total = 0;
  int n_pass  = 0;

  branch_resolve_unit_if #(.WIDTH(32), .PC_WIDTH(32)) bus ();

  branch_resolve_unit #(.WIDTH(32), .CHUNK(8), .PC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Scan length = position (from the MSB end) of the first differing byte,
  // or all four bytes when the operands are equal.
  function automatic int calc_chunks(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a ^ b;
    for (int i = 0; i < 4; i++)
      if (((d >> (24 - 8*i)) & 32'hFF) != 0) return i + 1;
    return 4;
  endfunction

  function automatic logic calc_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  bit          m_pend = 0;
  bit          m_rdy  = 0;
  int          m_age  = 0;
  int          m_lat  = 0;
  logic        m_tk   = 0;
  logic        m_il   = 0;
  logic [31:0] m_tg   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_rdy = 0; m_age = 0;
    end else if (flush) begin
      m_pend = 0; m_rdy = 1;
    end else if (m_pend) begin
      if (m_age >= m_lat && bus.out_ready) begin
        m_pend = 0; m_rdy = 1;
      end else begin
        m_age++;
      end
    end else if (m_rdy && bus.in_valid) begin
      m_pend = 1;
      m_rdy  = 0;
      m_age  = 0;
      m_il   = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);
      m_lat  = m_il ? 0 : calc_chunks(bus.rs1, bus.rs2);
      m_tk   = m_il ? 1'b0 : calc_taken(bus.funct3, bus.rs1, bus.rs2);
      m_tg   = bus.pc + bus.imm;
    end else begin
      m_rdy = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic mon_ev;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ev = m_pend && (m_age >= m_lat);
      chk("mon_in_ready",  {31'd0, bus.in_ready},  {31'd0, m_rdy});
      chk("mon_out_valid", {31'd0, bus.out_valid}, {31'd0, mon_ev});
      chk("mon_taken",     {31'd0, bus.taken},     {31'd0, mon_ev & m_tk});
      chk("mon_illegal",   {31'd0, bus.illegal},   {31'd0, mon_ev & m_il});
      chk("mon_target",    bus.target,             mon_ev ? m_tg : 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Issue one op (caller is at a negedge). In literal mode out_ready is held
  // low until the result appears, then hold extra cycles, then released.
  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] p, input logic [31:0] im, input bit lit,
                    input int ecyc, input logic etk, input logic eil,
                    input logic [31:0] etg, input int hold);
    int cyc;
    int n;
    wait_ready();
    bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b; bus.pc = p; bus.imm = im;
    bus.in_valid  = 1'b1;
    bus.out_ready = lit ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rs1 = $urandom; bus.rs2 = $urandom; bus.pc = $urandom; bus.imm = $urandom;
    bus.funct3 = 3'($urandom_range(0, 7));
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      if (!lit) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    if (lit) begin
      chk("lit_latency", cyc, ecyc);
      chk("lit_taken",   {31'd0, bus.taken},   {31'd0, etk});
      chk("lit_illegal", {31'd0, bus.illegal}, {31'd0, eil});
      chk("lit_target",  bus.target, etg);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp_taken",     {31'd0, bus.taken},     {31'd0, etk});
      chk("bp_target",    bus.target, etg);
    end
    n = 0;
    while (bus.out_valid && n < 50) begin
      bus.out_ready = lit ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (bus.out_valid) chk("release_timeout", {31'd0, bus.out_valid}, 32'd0);
    if (lit) chk("lit_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra, rb;
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0; bus.pc = '0; bus.imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_taken",     {31'd0, bus.taken},     32'd0);
    chk("rst_illegal",   {31'd0, bus.illegal},   32'd0);
    chk("rst_target",    bus.target, 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // directed cases with hand-computed expectations
    op(3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'h20, 1, 5, 1'b1, 1'b0, 32'h120, 0);
    op(3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 1, 2, 1'b1, 1'b0, 32'h0, 0);
    op(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 1, 2, 1'b0, 1'b0, 32'h0, 0);
    op(3'b001, 32'h0, 32'h1, 32'h40, 32'hFFFFFFFC, 1, 5, 1'b1, 1'b0, 32'h3C, 3);
    op(3'b101, 32'h80000000, 32'h80000000, 32'h8, 32'h8, 1, 5, 1'b1, 1'b0, 32'h10, 0);
    op(3'b000, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h20, 1, 5, 1'b1, 1'b0, 32'h10, 0);
    op(3'b010, 32'h5, 32'h5, 32'h200, 32'h4, 1, 1, 1'b0, 1'b1, 32'h204, 0);
    op(3'b100, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 1, 2, 1'b0, 1'b0, 32'h0, 0);
    op(3'b111, 32'h00000100, 32'h000000FF, 32'h0, 32'h0, 1, 4, 1'b1, 1'b0, 32'h0, 0);

    // flush in the second SCAN cycle
    wait_ready();
    bus.funct3 = 3'b000; bus.rs1 = 32'hA5A5A5A5; bus.rs2 = 32'hA5A5A5A5;
    bus.pc = 32'h10; bus.imm = 32'h10; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // flush wins over a request presented in IDLE
    bus.funct3 = 3'b010; bus.in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
    chk("flush_wins_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("flush_wins_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (3) @(negedge clk);

    // async reset while holding a result in DONE
    wait_ready();
    bus.funct3 = 3'b001; bus.rs1 = 32'h1; bus.rs2 = 32'h2;
    bus.pc = 32'h300; bus.imm = 32'h4; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("async_rst_taken",     {31'd0, bus.taken},     32'd0);
    chk("async_rst_target",    bus.target, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // randomized traffic with backpressure, idle gaps and occasional flushes
    for (int t = 0; t < 200; t++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2: rb = ra ^ 32'h80000000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        wait_ready();
        bus.funct3 = 3'($urandom_range(0, 7)); bus.rs1 = ra; bus.rs2 = rb;
        bus.pc = $urandom; bus.imm = $urandom; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 6)) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end else begin
        op(3'($urandom_range(0, 7)), ra, rb, $urandom, $urandom, 0, 0, 1'b0, 1'b0, 32'h0, 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
